// File: rtl/pong_pkg.sv
// Shared paddle-control types and levels for joystick, paddle and ball logic.
package pong_pkg;

    typedef enum logic [1:0] {
        NEUTRAL,
        UP,
        DOWN,
        GAP
    } joy_state_t;

    localparam logic CTRL_ACTIVE = 1'b0;
    localparam logic CTRL_IDLE   = 1'b1;

    // {control_up, control_down} for a given arbitration state
    function automatic logic [1:0] ctrl_of(input joy_state_t s);
        logic [1:0] c;
        c = {CTRL_IDLE, CTRL_IDLE};
        unique case (s)
            UP:      c = {CTRL_ACTIVE, CTRL_IDLE};
            DOWN:    c = {CTRL_IDLE, CTRL_ACTIVE};
            default: c = {CTRL_IDLE, CTRL_IDLE};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/joy_debounce.sv
// One joystick pin: 2-flop synchroniser, stable-count debounce and press strobe.
module joy_debounce
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clock,
    input  logic reset,
    input  logic pin_n,
    output logic pressed,
    output logic press
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             deb_prev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            deb      <= 1'b1;
            deb_prev <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync1    <= pin_n;
            sync2    <= sync1;
            deb_prev <= deb;
            press    <= deb_prev & ~deb;
            // any return to the accepted level restarts the stability count
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign pressed = ~deb;

endmodule

// File: rtl/joystick_ctrl.sv
// Per-player joystick driver: debounced pins arbitrated into active-low paddle controls.
// Define JOY_REVERSE_GAP_EN to force GAP_CYCLES neutral cycles on every UP<->DOWN reversal.
module joystick_ctrl
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int GAP_CYCLES      = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_up_n,
    input  logic btn_down_n,
    output logic control_up,
    output logic control_down,
    output logic up_pulse,
    output logic down_pulse
);

    logic       up_held;
    logic       down_held;
    joy_state_t state;
    joy_state_t nxt;

    joy_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_up (
        .clock  (clock),
        .reset  (reset),
        .pin_n  (btn_up_n),
        .pressed(up_held),
        .press  (up_pulse)
    );

    joy_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_down (
        .clock  (clock),
        .reset  (reset),
        .pin_n  (btn_down_n),
        .pressed(down_held),
        .press  (down_pulse)
    );

`ifdef JOY_REVERSE_GAP_EN
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    logic [GAP_W-1:0] gap_cnt;
    logic             gap_done;

    assign gap_done = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            NEUTRAL: begin
                if (up_held && !down_held)
                    nxt = UP;
                else if (down_held && !up_held)
                    nxt = DOWN;
            end
            UP: begin
                if (!up_held) begin
`ifdef JOY_REVERSE_GAP_EN
                    nxt = down_held ? GAP : NEUTRAL;
`else
                    nxt = down_held ? DOWN : NEUTRAL;
`endif
                end
            end
            DOWN: begin
                if (!down_held) begin
`ifdef JOY_REVERSE_GAP_EN
                    nxt = up_held ? GAP : NEUTRAL;
`else
                    nxt = up_held ? UP : NEUTRAL;
`endif
                end
            end
`ifdef JOY_REVERSE_GAP_EN
            GAP: begin
                if (gap_done) begin
                    if (up_held && !down_held)
                        nxt = UP;
                    else if (down_held && !up_held)
                        nxt = DOWN;
                    else
                        nxt = NEUTRAL;
                end
            end
`endif
            default: nxt = NEUTRAL;
        endcase
    end

    // outputs are registered from the next state so they can never glitch to {0,0}
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= NEUTRAL;
            control_up   <= CTRL_IDLE;
            control_down <= CTRL_IDLE;
`ifdef JOY_REVERSE_GAP_EN
            gap_cnt      <= '0;
`endif
        end else begin
            state                      <= nxt;
            {control_up, control_down} <= ctrl_of(nxt);
`ifdef JOY_REVERSE_GAP_EN
            gap_cnt <= (state == GAP && nxt == GAP) ? gap_cnt + 1'b1 : '0;
`endif
        end
    end

endmodule

// File: tb/tb_joystick_ctrl.sv
// Self-checking bench for joystick_ctrl against a cycle-level behavioural model.
module tb_joystick_ctrl;

    localparam int D = 4;
    localparam int G = 3;
`ifdef JOY_REVERSE_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic btn_up_n = 1'b1;
    logic btn_down_n = 1'b1;
    logic control_up;
    logic control_down;
    logic up_pulse;
    logic down_pulse;

    int n_pass = 0;
    int n_total = 0;

    joystick_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3),
        .GAP_CYCLES     (G)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_up_n    (btn_up_n),
        .btn_down_n  (btn_down_n),
        .control_up  (control_up),
        .control_down(control_down),
        .up_pulse    (up_pulse),
        .down_pulse  (down_pulse)
    );

    always #5 clock = ~clock;

    // model: pin history -> accepted levels -> owning direction
    bit m_s1[2];
    bit m_s2[2];
    bit m_deb[2];
    int m_run[2];
    bit m_fell[2];
    bit m_pulse[2];
    int m_dir;
    int m_gap_left;

    always @(posedge clock) begin : model
        bit raw[2];
        bit held[2];
        bit obs;
        raw[0] = btn_up_n;
        raw[1] = btn_down_n;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 1; m_s2[i] = 1; m_deb[i] = 1;
                m_run[i] = 0; m_fell[i] = 0; m_pulse[i] = 0;
            end
            m_dir = 0;
            m_gap_left = 0;
        end else begin
            held[0] = !m_deb[0];
            held[1] = !m_deb[1];
            if (m_gap_left > 0) begin
                if (m_gap_left == 1) begin
                    m_gap_left = 0;
                    m_dir = (held[0] && !held[1]) ? 1 : (held[1] && !held[0]) ? 2 : 0;
                end else begin
                    m_gap_left--;
                end
            end else if (m_dir == 0) begin
                m_dir = (held[0] && !held[1]) ? 1 : (held[1] && !held[0]) ? 2 : 0;
            end else if (held[m_dir-1]) begin
                m_dir = m_dir;
            end else if (held[2-m_dir]) begin
                if (GAP_EN) begin
                    m_dir = 0;
                    m_gap_left = G;
                end else begin
                    m_dir = 3 - m_dir;
                end
            end else begin
                m_dir = 0;
            end
            for (int i = 0; i < 2; i++) begin
                m_pulse[i] = m_fell[i];
                m_fell[i] = 0;
                obs = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
                if (obs == m_deb[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_deb[i] = obs;
                        m_run[i] = 0;
                        m_fell[i] = (obs == 0);
                    end
                end
            end
        end
    end

    function automatic logic [3:0] exp_vec();
        return {logic'(m_dir != 1), logic'(m_dir != 2),
                logic'(m_pulse[0]), logic'(m_pulse[1])};
    endfunction

    function automatic logic [3:0] got_vec();
        return {control_up, control_down, up_pulse, down_pulse};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        btn_up_n = 1'b1;
        btn_down_n = 1'b1;
        repeat (2) @(negedge clock);
        n_total++;
        if (got_vec() !== 4'b1100)
            $display("FAIL reset_state got=%b want=1100", got_vec());
        else
            n_pass++;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_total++;
        if (got_vec() !== exp_vec())
            $display("FAIL reset_idle got=%b want=%b", got_vec(), exp_vec());
        else
            n_pass++;
    endtask

    task automatic test_press();
        btn_up_n = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            n_total++;
            if (got_vec() !== exp_vec())
                $display("FAIL press_model cyc=%0d got=%b want=%b", i, got_vec(), exp_vec());
            else
                n_pass++;
            if (i == 6) begin
                n_total++;
                if (control_up !== 1'b1)
                    $display("FAIL press_early cu=%b want=1", control_up);
                else
                    n_pass++;
            end
            if (i == 7) begin
                n_total++;
                if (got_vec() !== 4'b0110)
                    $display("FAIL press_latency got=%b want=0110", got_vec());
                else
                    n_pass++;
            end
            if (i == 8) begin
                n_total++;
                if (up_pulse !== 1'b0)
                    $display("FAIL press_pulse_width up_pulse=%b want=0", up_pulse);
                else
                    n_pass++;
            end
        end
        btn_up_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            n_total++;
            if (got_vec() !== exp_vec())
                $display("FAIL release_model cyc=%0d got=%b want=%b", i, got_vec(), exp_vec());
            else
                n_pass++;
        end
        n_total++;
        if (got_vec() !== 4'b1100)
            $display("FAIL release_idle got=%b want=1100", got_vec());
        else
            n_pass++;
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 30; k++) begin
            btn_up_n = (k < 20) ? logic'((k % 4) >= 2) : 1'b1;
            @(negedge clock);
            n_total++;
            if (got_vec() !== 4'b1100 || exp_vec() !== 4'b1100)
                $display("FAIL bounce cyc=%0d got=%b model=%b want=1100", k, got_vec(), exp_vec());
            else
                n_pass++;
        end
    endtask

    task automatic test_reverse();
        int pulses;
        int idle;
        bit done;
        btn_up_n = 1'b0;
        repeat (10) @(negedge clock);
        n_total++;
        if (got_vec() !== 4'b0100)
            $display("FAIL rev_up got=%b want=0100", got_vec());
        else
            n_pass++;
        btn_down_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            pulses += int'(down_pulse);
            n_total++;
            if (got_vec() !== exp_vec() || got_vec() ==? 4'b00??)
                $display("FAIL rev_hold cyc=%0d got=%b want=%b", i, got_vec(), exp_vec());
            else
                n_pass++;
        end
        n_total++;
        if (control_up !== 1'b0 || pulses != 1)
            $display("FAIL rev_keep_up cu=%b pulses=%0d want cu=0 pulses=1", control_up, pulses);
        else
            n_pass++;
        btn_up_n = 1'b1;
        idle = 0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            n_total++;
            if (got_vec() !== exp_vec() || got_vec() ==? 4'b00??)
                $display("FAIL rev_switch cyc=%0d got=%b want=%b", i, got_vec(), exp_vec());
            else
                n_pass++;
            if ({control_up, control_down} == 2'b11) idle++;
            if ({control_up, control_down} == 2'b10) done = 1;
        end
        n_total++;
        if (!done || idle != (GAP_EN ? G : 0))
            $display("FAIL rev_gap reached=%0d idle=%0d want idle=%0d", done, idle, GAP_EN ? G : 0);
        else
            n_pass++;
        btn_down_n = 1'b1;
        repeat (10) @(negedge clock);
        n_total++;
        if (got_vec() !== 4'b1100)
            $display("FAIL rev_release got=%b want=1100", got_vec());
        else
            n_pass++;
    endtask

    task automatic test_both();
        int up_cnt;
        int dn_cnt;
        up_cnt = 0;
        dn_cnt = 0;
        btn_up_n = 1'b0;
        btn_down_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            up_cnt += int'(up_pulse);
            dn_cnt += int'(down_pulse);
            n_total++;
            if (got_vec() !== exp_vec() || {control_up, control_down} !== 2'b11)
                $display("FAIL both_hold cyc=%0d got=%b want=%b", i, got_vec(), exp_vec());
            else
                n_pass++;
            if (i == 7) begin
                n_total++;
                if (got_vec() !== 4'b1111)
                    $display("FAIL both_pulses got=%b want=1111", got_vec());
                else
                    n_pass++;
            end
        end
        n_total++;
        if (up_cnt != 1 || dn_cnt != 1)
            $display("FAIL both_count up=%0d down=%0d want 1 1", up_cnt, dn_cnt);
        else
            n_pass++;
        btn_up_n = 1'b1;
        btn_down_n = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int lat;
        btn_up_n = 1'b0;
        repeat (10) @(negedge clock);
        n_total++;
        if (got_vec() !== 4'b0100)
            $display("FAIL rst_mid_pre got=%b want=0100", got_vec());
        else
            n_pass++;
        reset = 1'b1;
        @(negedge clock);
        n_total++;
        if (got_vec() !== 4'b1100)
            $display("FAIL rst_mid_idle got=%b want=1100", got_vec());
        else
            n_pass++;
        reset = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clock);
            if (control_up === 1'b0) lat = i;
        end
        n_total++;
        if (lat != 7)
            $display("FAIL rst_mid_latency got=%0d want=7", lat);
        else
            n_pass++;
        btn_up_n = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                btn_up_n = logic'($urandom_range(0, 1));
                btn_down_n = logic'($urandom_range(0, 1));
                hold = $urandom_range(1, 12);
            end
            hold--;
            reset = ($urandom_range(0, 149) == 0);
            @(negedge clock);
            n_total++;
            if (got_vec() !== exp_vec() || got_vec() ==? 4'b00??)
                $display("FAIL random cyc=%0d got=%b want=%b", i, got_vec(), exp_vec());
            else
                n_pass++;
        end
        reset = 1'b0;
        btn_up_n = 1'b1;
        btn_down_n = 1'b1;
        repeat (12) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_reverse();
        test_both();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
